// File: rtl/wb_stage_pkg.sv
// Shared write-back definitions: load size/sign encodings and datapath width defaults.
package wb_stage_pkg;
   localparam int DATA_W_DEF     = 32;
   localparam int REG_ADDR_W_DEF = 5;

   typedef enum logic [2:0] {
      LT_LW  = 3'd0,
      LT_LB  = 3'd1,
      LT_LBU = 3'd2,
      LT_LH  = 3'd3,
      LT_LHU = 3'd4
   } load_type_e;
endpackage

// File: rtl/wb_load_align.sv
// Load lane select and sign/zero extension, little-endian byte lanes.
// Purely combinational; unknown load codes pass the whole word through as LW.
module wb_load_align
   import wb_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] i_raw,
   input  logic [1:0]        i_offset,
   input  logic [2:0]        i_load_type,
   output logic [DATA_W-1:0] o_data
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_raw[7:0];
      case (i_offset)
         2'd1:    w_byte = i_raw[15:8];
         2'd2:    w_byte = i_raw[23:16];
         2'd3:    w_byte = i_raw[31:24];
         default: w_byte = i_raw[7:0];
      endcase
      // halfwords use only offset[1]; a misaligned offset[0] is ignored
      w_half = i_offset[1] ? i_raw[31:16] : i_raw[15:0];

      o_data = i_raw;
      case (i_load_type)
         LT_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
         LT_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
         LT_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
         LT_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
         default: o_data = i_raw;
      endcase
   end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB register and register-file write driver; outputs 1 cycle after MEM capture.
// stall holds the stage (write re-asserted each cycle), flush beats stall; WB_RETIRE_CNT_EN adds a retire counter.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_valid,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [DATA_W-1:0]     ALUResult,
   input  logic [DATA_W-1:0]     MemReadData,
   input  logic [REG_ADDR_W-1:0] WriteReg_in,
   input  logic                  RegWrite_in,
   input  logic                  MemtoReg_in,
   input  logic [2:0]            LoadType_in,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0]     WriteData,
   output logic                  wb_valid,
   output logic [CNT_W-1:0]      retire_count
);
   logic                  r_valid;
   logic                  r_regwrite;
   logic                  r_memtoreg;
   logic [2:0]            r_load_type;
   logic [REG_ADDR_W-1:0] r_wreg;
   logic [DATA_W-1:0]     r_alu;
   logic [DATA_W-1:0]     r_mem_rdata;
   logic [DATA_W-1:0]     w_load_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush) begin
         r_valid     <= 1'b0;
         r_regwrite  <= 1'b0;
         r_memtoreg  <= 1'b0;
         r_load_type <= '0;
         r_wreg      <= '0;
         r_alu       <= '0;
         r_mem_rdata <= '0;
      end else if (!stall) begin
         r_valid     <= mem_valid;
         r_regwrite  <= RegWrite_in;
         r_memtoreg  <= MemtoReg_in;
         r_load_type <= LoadType_in;
         r_wreg      <= WriteReg_in;
         r_alu       <= ALUResult;
         r_mem_rdata <= MemReadData;
      end
   end

   wb_load_align #(.DATA_W(DATA_W)) u_load_align (
      .i_raw       (r_mem_rdata),
      .i_offset    (r_alu[1:0]),
      .i_load_type (r_load_type),
      .o_data      (w_load_data)
   );

   // R0 is hardwired zero, so a write to it is never presented to the register file
   assign RegWrite  = r_valid & r_regwrite & (r_wreg != '0);
   assign WriteReg  = r_wreg;
   assign WriteData = r_memtoreg ? w_load_data : r_alu;
   assign wb_valid  = r_valid;

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] r_retire_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_retire_cnt <= '0;
      else if (r_valid && !stall && (r_retire_cnt != '1))
         r_retire_cnt <= r_retire_cnt + 1'b1;
   end

   assign retire_count = r_retire_cnt;
`else
   assign retire_count = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/load write-back, R0 guard, stall/flush, retire counter, async reset.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid, stall, flush;
   logic [31:0] ALUResult, MemReadData;
   logic [4:0]  WriteReg_in;
   logic        RegWrite_in, MemtoReg_in;
   logic [2:0]  LoadType_in;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        wb_valid;
   logic [31:0] retire_count;

   int checks = 0;
   int errors = 0;

`ifdef WB_RETIRE_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   wb_stage dut (
      .clk          (clk),
      .reset        (reset),
      .mem_valid    (mem_valid),
      .stall        (stall),
      .flush        (flush),
      .ALUResult    (ALUResult),
      .MemReadData  (MemReadData),
      .WriteReg_in  (WriteReg_in),
      .RegWrite_in  (RegWrite_in),
      .MemtoReg_in  (MemtoReg_in),
      .LoadType_in  (LoadType_in),
      .RegWrite     (RegWrite),
      .WriteReg     (WriteReg),
      .WriteData    (WriteData),
      .wb_valid     (wb_valid),
      .retire_count (retire_count)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] wr, input logic m2r,
                        input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] mrd);
      mem_valid   = v;
      RegWrite_in = rw;
      WriteReg_in = wr;
      MemtoReg_in = m2r;
      LoadType_in = lt;
      ALUResult   = alu;
      MemReadData = mrd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wb(input string tag, input logic rw, input logic [4:0] wr,
                           input logic [31:0] wd, input logic v);
      check({tag, ".RegWrite"},  64'(RegWrite),  64'(rw));
      check({tag, ".WriteReg"},  64'(WriteReg),  64'(wr));
      check({tag, ".WriteData"}, 64'(WriteData), 64'(wd));
      check({tag, ".wb_valid"},  64'(wb_valid),  64'(v));
   endtask

   // load vectors against raw word 0x8081F2F3: {type, address, expected}
   logic [2:0]  ld_type [7] = '{LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LW, LT_LH, 3'd7};
   logic [31:0] ld_addr [7] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100, 32'h103, 32'h102};
   logic [31:0] ld_exp  [7] = '{32'hFFFFFFF2, 32'h00000080, 32'hFFFF8081, 32'h0000F2F3,
                                32'h8081F2F3, 32'hFFFF8081, 32'h8081F2F3};

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(0, 0, 0, 0, LT_LW, 0, 0);
      tick();
      tick();
      check_wb("reset", 0, 0, 32'h0, 0);
      check("reset.retire", 64'(retire_count), 64'h0);
      reset = 1'b0;

      // ALU op
      drive(1, 1, 5'd3, 0, LT_LW, 32'h10, 32'h0);
      tick();
      check_wb("alu", 1, 5'd3, 32'h10, 1);

      // loads
      for (int i = 0; i < 7; i++) begin
         drive(1, 1, 5'd4, 1, ld_type[i], ld_addr[i], 32'h8081F2F3);
         tick();
         check($sformatf("load%0d.data", i), 64'(WriteData), 64'(ld_exp[i]));
      end
      check("load.RegWrite", 64'(RegWrite), 64'h1);

      // R0 guard
      drive(1, 1, 5'd0, 0, LT_LW, 32'hDEADBEEF, 32'h0);
      tick();
      check_wb("r0", 0, 5'd0, 32'hDEADBEEF, 1);

      // flush beats stall
      drive(1, 1, 5'd7, 0, LT_LW, 32'h77, 32'h0);
      stall = 1'b1;
      flush = 1'b1;
      tick();
      check("flush.wb_valid", 64'(wb_valid), 64'h0);
      check("flush.RegWrite", 64'(RegWrite), 64'h0);
      stall = 1'b0;
      flush = 1'b0;

      // stall holds R5 <= 0xAAAA5555 while new MEM data is offered
      drive(1, 1, 5'd5, 0, LT_LW, 32'hAAAA5555, 32'h0);
      tick();
      check_wb("stall.cap", 1, 5'd5, 32'hAAAA5555, 1);
      stall = 1'b1;
      drive(1, 1, 5'd9, 1, LT_LB, 32'h1234, 32'hFFFFFFFF);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_wb($sformatf("stall%0d", c), 1, 5'd5, 32'hAAAA5555, 1);
      end
      stall = 1'b0;
      drive(0, 0, 0, 0, LT_LW, 0, 0);
      tick();
      check("bubble.wb_valid", 64'(wb_valid), 64'h0);
      check("bubble.RegWrite", 64'(RegWrite), 64'h0);

      // retire counter: 4 retire, 1 flushed, 1 stalled 2 cycles
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1, 1, 5'd1, 0, LT_LW, 32'h1, 0);
      tick();
      drive(1, 1, 5'd2, 0, LT_LW, 32'h2, 0);
      tick();
      check("cnt.after1", 64'(retire_count), CNT_ON ? 64'd1 : 64'd0);
      drive(1, 1, 5'd3, 0, LT_LW, 32'h3, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("cnt.flush.wb_valid", 64'(wb_valid), 64'h0);
      drive(1, 0, 5'd4, 0, LT_LW, 32'h4, 0);
      tick();
      stall = 1'b1;
      tick();
      tick();
      check("cnt.stalled", 64'(retire_count), CNT_ON ? 64'd2 : 64'd0);
      check("cnt.stalled.RegWrite", 64'(RegWrite), 64'h0);
      stall = 1'b0;
      drive(1, 1, 5'd6, 0, LT_LW, 32'h6, 0);
      tick();
      drive(0, 0, 0, 0, LT_LW, 0, 0);
      tick();
      tick();
      check("cnt.final", 64'(retire_count), CNT_ON ? 64'd4 : 64'd0);

      // asynchronous reset mid-instruction
      drive(1, 1, 5'd6, 0, LT_LW, 32'h66, 0);
      tick();
      check_wb("pre_rst", 1, 5'd6, 32'h66, 1);
      #2 reset = 1'b1;
      #1;
      check_wb("async_rst", 0, 0, 32'h0, 0);
      check("async_rst.retire", 64'(retire_count), 64'h0);
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, LT_LW, 0, 0);
      tick();
      check("post_rst.wb_valid", 64'(wb_valid), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
